// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern sequence detector.
//   MODE_OVERLAP / MODE_NONOVERLAP : values of overlap_en
//   fill_state_t                   : detector state, derived from the fill count
//   DEFAULT_N / DEFAULT_CW         : default pattern length and match-counter width
package seq_det_pkg;

  localparam logic MODE_OVERLAP    = 1'b1;
  localparam logic MODE_NONOVERLAP = 1'b0;

  localparam int DEFAULT_N  = 4;
  localparam int DEFAULT_CW = 8;

  typedef enum logic [1:0] {
    FS_EMPTY   = 2'd0,
    FS_PARTIAL = 2'd1,
    FS_ARMED   = 2'd2,
    FS_MATCH   = 2'd3
  } fill_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   rst   : synchronous active-high reset, clears count
//   clr   : clears count; wins over inc
//   inc   : add one unless already at all-ones
//   count : current count value
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/pattern_sequence_detector.sv
// Serial pattern detector with selectable overlapping / non-overlapping
// detection, runtime-loadable pattern and a saturating match counter.
//   clk, rst       : clock, synchronous active-high reset
//   din, din_valid : serial data bit, accepted only when din_valid is high
//   overlap_en     : 1 = overlapping detection, 0 = non-overlapping
//   cfg_load       : one-cycle pulse loading cfg_pattern (MSB = earliest bit)
//   cnt_clr        : clears match_count
//   dout           : registered one-cycle match pulse
//   match_count    : saturating number of matches
//   active_pattern : pattern currently being searched for
//
// state      | meaning
// FS_EMPTY   | fill = 0, no usable history
// FS_PARTIAL | 0 < fill < N-1, collecting bits
// FS_ARMED   | fill >= N-1, the next accepted bit can complete a match
// FS_MATCH   | current accepted bit completes the pattern
module pattern_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int             N       = DEFAULT_N,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             CW      = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          din_valid,
  input  logic          overlap_en,
  input  logic          cfg_load,
  input  logic [N-1:0]  cfg_pattern,
  input  logic          cnt_clr,
  output logic          dout,
  output logic [CW-1:0] match_count,
  output logic [N-1:0]  active_pattern
);

  localparam int             FW        = $clog2(N + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [FW-1:0]  FILL_ARM  = FW'(N - 1);

  // Only the newest N-1 bits can contribute to a match together with the
  // incoming bit, so the oldest history bit is not stored.
  logic [N-2:0]  hist, hist_nxt;
  logic [FW-1:0] fill, fill_nxt;
  logic          dout_nxt;
  logic [N-1:0]  shifted;
  logic          match_now;
  logic          match_inc;
  fill_state_t   state;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist           <= '0;
      fill           <= '0;
      dout           <= 1'b0;
      active_pattern <= PATTERN;
    end else begin
      hist <= hist_nxt;
      fill <= fill_nxt;
      dout <= dout_nxt;
      if (cfg_load) begin
        active_pattern <= cfg_pattern;
      end
    end
  end

  always_comb begin
    hist_nxt  = hist;
    fill_nxt  = fill;
    dout_nxt  = 1'b0;
    shifted   = {hist, din};
    match_now = din_valid && (fill >= FILL_ARM) && (shifted == active_pattern);

    if (match_now) begin
      state = FS_MATCH;
    end else if (fill == '0) begin
      state = FS_EMPTY;
    end else if (fill < FILL_ARM) begin
      state = FS_PARTIAL;
    end else begin
      state = FS_ARMED;
    end

    // A pattern load discards the incoming bit and restarts collection.
    if (cfg_load) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (din_valid) begin
      hist_nxt = shifted[N-2:0];
      dout_nxt = match_now;
      case (state)
        FS_MATCH:   fill_nxt = (overlap_en == MODE_OVERLAP) ? FILL_FULL : '0;
        FS_ARMED:   fill_nxt = FILL_FULL;
        default:    fill_nxt = fill + FW'(1);
      endcase
    end
  end

  // A discarded bit (cfg_load cycle) is not counted as a match.
  assign match_inc = match_now && !cfg_load;

  sat_counter #(.CW(CW)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (match_inc),
    .count (match_count)
  );

endmodule

// File: doc/pattern_sequence_detector.md
PATTERN_SEQUENCE_DETECTOR -- requirements
Module: pattern_sequence_detector

Interface
REQ-001 SHALL have parameter N, default 4, pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter PATTERN, default 4'b1011 (width N), the pattern loaded at reset, MSB = earliest bit.
REQ-003 SHALL have parameter CW, default 8, match-counter width.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 din  input  1  serial data bit.
REQ-007 din_valid  input  1  din is accepted on this edge only when high.
REQ-008 overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 cfg_load  input  1  single-cycle pulse that loads cfg_pattern.
REQ-010 cfg_pattern  input  N  new pattern, MSB = earliest bit.
REQ-011 cnt_clr  input  1  clears match_count.
REQ-012 dout  output  1  registered match pulse.
REQ-013 match_count  output  CW  saturating count of matches.
REQ-014 active_pattern  output  N  currently loaded pattern register.

Function
REQ-015 SHALL keep a history register hist[N-1:0] and a fill counter fill (0..N).
- Accepted bit: hist <= {hist[N-2:0], din}; fill <= min(fill+1, N).
REQ-016 SHALL compute match_now = din_valid & (fill >= N-1) & ({hist[N-2:0],din} == active_pattern).
REQ-017 SHALL register dout <= match_now.
- dout is high for exactly one cycle, in the cycle after the edge that accepted the final pattern bit (latency 1).
REQ-018 When din_valid=0, hist and fill SHALL hold and dout SHALL be 0 next cycle; gaps in valid do not break a partial match.
REQ-019 In overlap mode (overlap_en=1), fill SHALL remain N after a match, so a suffix of the match may start the next one.
REQ-020 In non-overlap mode (overlap_en=0), fill SHALL be set to 0 on the match edge, so the next match needs N fresh bits.
REQ-021 overlap_en SHALL be sampled every edge.
- A change takes effect on the next accepted bit.
- It does not alter hist.
REQ-022 On cfg_load=1: active_pattern <= cfg_pattern; fill <= 0; hist <= 0; dout <= 0.
- din is discarded that cycle even if din_valid=1 (cfg_load wins).
REQ-023 match_count SHALL increment by 1 on every edge where match_now=1.
- Saturates at 2^CW-1 and does not wrap.
REQ-024 cnt_clr SHALL set match_count to 0.
- cnt_clr together with match_now gives 0; clear wins.
- cfg_load SHALL NOT alter match_count.
REQ-025 State machine for fill tracking (encoded by fill):
- EMPTY (fill=0) -> PARTIAL (0<fill<N-1) -> ARMED (fill>=N-1) -> MATCH.
- MATCH returns to ARMED in overlap mode, or EMPTY in non-overlap mode.

Reset
REQ-026 On rst=1 at posedge clk, the block SHALL set:
- active_pattern=PATTERN, hist=0, fill=0, dout=0, match_count=0.
REQ-027 rst SHALL take priority over cfg_load, cnt_clr and din_valid, including mid-pattern.
- Partial history is discarded.
REQ-028 No output SHALL be X after the first reset edge.

Structure
REQ-029 Package seq_det_pkg SHALL hold:
- the MODE_OVERLAP/MODE_NONOVERLAP constants;
- the fill-state encoding;
- default N/CW constants.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (params CW; ports clk, rst, clr, inc, count).
- All other logic stays in pattern_sequence_detector.

Verification (N=4, PATTERN=1011, din_valid=1 unless stated)
REQ-031 overlap_en=1, din stream 1,0,1,1,0,1,1:
- dout pulses after bit 4 and after bit 7.
- match_count=2.
REQ-032 overlap_en=0, same stream 1,0,1,1,0,1,1:
- dout pulses after bit 4 only.
- match_count=1.
REQ-033 Stream 1,0,1 with din_valid=0 for 3 cycles, then 1:
- dout pulses once, after the final 1.
- No pulse during the gap.
REQ-034 cfg_load with cfg_pattern=1110 asserted after bits 1,0,1, then stream 1,1,1,0:
- No match from the prior partial.
- dout pulses after the 0.
- active_pattern=1110.
REQ-035 CW=2, overlap_en=1, stream 1011 followed by 011 repeated 5 times:
- match_count saturates at 3.
- cnt_clr coincident with a match gives 0.
REQ-036 rst asserted after bits 1,0,1, then din=1:
- No match.
- All outputs 0; active_pattern=1011.
